// File: rtl/serial_addsub_engine.sv
// Bit-serial WIDTH-bit adder/subtractor: one bit pair per clock, LSB first, carry/borrow in a flop.
// Optional signed-overflow output is compiled in with `define SERIAL_ADDSUB_OVF_EN.
module serial_addsub_engine #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cb_out
`ifdef SERIAL_ADDSUB_OVF_EN
   ,
   output logic             ovf_out
`endif
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [WIDTH-1:0] a_sh_q, b_sh_q, result_q;
   logic [CW-1:0]    cnt_q;
   logic             cb_q, op_sub_q;
   logic             accept, shift_en;
   logic             bit_a, bit_b, sum_bit, cb_d;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_SHIFT;
         S_SHIFT: if (cnt_q == LAST_BIT) state_d = S_DONE;
         S_DONE:  state_d = start ? S_SHIFT : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy     = (state_q == S_SHIFT);
      done     = (state_q == S_DONE);
      shift_en = (state_q == S_SHIFT);
      accept   = start && (state_q != S_SHIFT);
   end

   // Single-bit full adder/subtractor cell fed from the operand LSBs.
   always_comb begin
      bit_a   = a_sh_q[0];
      bit_b   = b_sh_q[0];
      sum_bit = bit_a ^ bit_b ^ cb_q;
      if (op_sub_q) begin
         cb_d = (~bit_a & bit_b) | (bit_b & cb_q) | (cb_q & ~bit_a);
      end else begin
         cb_d = (bit_a & bit_b) | (bit_b & cb_q) | (cb_q & bit_a);
      end
   end

   // ---------------- Datapath ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         cb_q     <= 1'b0;
         op_sub_q <= 1'b0;
      end else if (accept) begin
         a_sh_q   <= a_in;
         b_sh_q   <= b_in;
         op_sub_q <= op_sub;
         cb_q     <= 1'b0;
         cnt_q    <= '0;
      end else if (shift_en) begin
         a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
         b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
         result_q <= {sum_bit, result_q[WIDTH-1:1]};
         cb_q     <= cb_d;
         cnt_q    <= cnt_q + 1'b1;
      end
   end

   assign result = result_q;
   assign cb_out = cb_q;

`ifdef SERIAL_ADDSUB_OVF_EN
   // Operand sign bits are shifted away, so keep copies for the overflow test.
   logic a_msb_q, b_msb_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
      end else if (accept) begin
         a_msb_q <= a_in[WIDTH-1];
         b_msb_q <= b_in[WIDTH-1];
      end
   end

   always_comb begin
      if (op_sub_q) begin
         ovf_out = (a_msb_q != b_msb_q) && (result_q[WIDTH-1] != a_msb_q);
      end else begin
         ovf_out = (a_msb_q == b_msb_q) && (result_q[WIDTH-1] != a_msb_q);
      end
   end
`endif

endmodule

// File: tb/tb_serial_addsub_engine.sv
// Directed self-checking bench for serial_addsub_engine at WIDTH=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_serial_addsub_engine;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         op_sub;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cb_out;
`ifdef SERIAL_ADDSUB_OVF_EN
   logic         ovf_out;
`endif

   int total = 0;
   int bad   = 0;

   serial_addsub_engine #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op_sub (op_sub),
      .a_in   (a_in),
      .b_in   (b_in),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cb_out (cb_out)
`ifdef SERIAL_ADDSUB_OVF_EN
      ,
      .ovf_out(ovf_out)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Launch one operation and wait for done; lat counts cycles from the start edge.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        output int lat, output int busy_cycles, output logic timed_out);
      @(negedge clk);
      a_in   = a;
      b_in   = b;
      op_sub = sub;
      start  = 1'b1;
      @(negedge clk);
      start       = 1'b0;
      lat         = 1;
      busy_cycles = 0;
      while (done !== 1'b1 && lat < 40) begin
         if (busy === 1'b1) busy_cycles++;
         @(negedge clk);
         lat++;
      end
      timed_out = (done !== 1'b1);
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      start  = 1'b0;
      op_sub = 1'b0;
      a_in   = '0;
      b_in   = '0;
      repeat (2) @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
      total++; if (result !== 8'h00) begin bad++; $display("FAIL reset_result: got %h want 00", result); end
      total++; if (cb_out !== 1'b0) begin bad++; $display("FAIL reset_cb: got %b want 0", cb_out); end
      rst_n = 1'b1;
      @(negedge clk);
      $display("reset: busy=%b done=%b result=%h cb=%b", busy, done, result, cb_out);
   endtask

   task automatic test_add();
      int lat, bc;
      logic to;
      do_op(8'h3C, 8'h55, 1'b0, lat, bc, to);
      $display("add 3C+55: result=%h cb=%b lat=%0d busy=%0d", result, cb_out, lat, bc);
      total++; if (to) begin bad++; $display("FAIL add1_timeout: no done within bound"); end
      total++; if (result !== 8'h91) begin bad++; $display("FAIL add1_result: got %h want 91", result); end
      total++; if (cb_out !== 1'b0) begin bad++; $display("FAIL add1_cb: got %b want 0", cb_out); end
      total++; if (lat != 9) begin bad++; $display("FAIL add1_latency: got %0d want 9", lat); end
      total++; if (bc != 8) begin bad++; $display("FAIL add1_busy_cycles: got %0d want 8", bc); end
`ifdef SERIAL_ADDSUB_OVF_EN
      total++; if (ovf_out !== 1'b1) begin bad++; $display("FAIL add1_ovf: got %b want 1", ovf_out); end
`endif
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL add1_done_pulse: got %b want 0", done); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL add1_idle_busy: got %b want 0", busy); end
      total++; if (result !== 8'h91) begin bad++; $display("FAIL add1_hold: got %h want 91", result); end

      do_op(8'hFF, 8'h01, 1'b0, lat, bc, to);
      $display("add FF+01: result=%h cb=%b lat=%0d", result, cb_out, lat);
      total++; if (to) begin bad++; $display("FAIL add2_timeout: no done within bound"); end
      total++; if (result !== 8'h00) begin bad++; $display("FAIL add2_result: got %h want 00", result); end
      total++; if (cb_out !== 1'b1) begin bad++; $display("FAIL add2_cb: got %b want 1", cb_out); end
`ifdef SERIAL_ADDSUB_OVF_EN
      total++; if (ovf_out !== 1'b0) begin bad++; $display("FAIL add2_ovf: got %b want 0", ovf_out); end
`endif
   endtask

   task automatic test_sub();
      int lat, bc;
      logic to;
      do_op(8'h10, 8'h20, 1'b1, lat, bc, to);
      $display("sub 10-20: result=%h cb=%b lat=%0d", result, cb_out, lat);
      total++; if (to) begin bad++; $display("FAIL sub1_timeout: no done within bound"); end
      total++; if (result !== 8'hF0) begin bad++; $display("FAIL sub1_result: got %h want F0", result); end
      total++; if (cb_out !== 1'b1) begin bad++; $display("FAIL sub1_borrow: got %b want 1", cb_out); end
`ifdef SERIAL_ADDSUB_OVF_EN
      total++; if (ovf_out !== 1'b0) begin bad++; $display("FAIL sub1_ovf: got %b want 0", ovf_out); end
`endif
      do_op(8'h80, 8'h01, 1'b1, lat, bc, to);
      $display("sub 80-01: result=%h cb=%b lat=%0d", result, cb_out, lat);
      total++; if (to) begin bad++; $display("FAIL sub2_timeout: no done within bound"); end
      total++; if (result !== 8'h7F) begin bad++; $display("FAIL sub2_result: got %h want 7F", result); end
      total++; if (cb_out !== 1'b0) begin bad++; $display("FAIL sub2_borrow: got %b want 0", cb_out); end
`ifdef SERIAL_ADDSUB_OVF_EN
      total++; if (ovf_out !== 1'b1) begin bad++; $display("FAIL sub2_ovf: got %b want 1", ovf_out); end
`endif
   endtask

   task automatic test_back_to_back();
      int n;
      @(negedge clk);
      a_in = 8'h01; b_in = 8'h01; op_sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;                      // busy cycle 1
      @(negedge clk);                    // busy cycle 2
      @(negedge clk);                    // busy cycle 3: start must be ignored
      a_in = 8'hFF; b_in = 8'hFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a_in = 8'h0F; b_in = 8'h0E; op_sub = 1'b1;
      n = 0;
      while (done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      $display("ignore-start 01+01: result=%h cb=%b", result, cb_out);
      total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_first_timeout: done=%b want 1", done); end
      total++; if (result !== 8'h02) begin bad++; $display("FAIL b2b_first_result: got %h want 02", result); end
      total++; if (cb_out !== 1'b0) begin bad++; $display("FAIL b2b_first_cb: got %b want 0", cb_out); end
      start = 1'b1;                      // accepted in DONE, no IDLE gap
      @(negedge clk);
      start = 1'b0;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_restart_busy: got %b want 1", busy); end
      n = 1;
      while (done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      $display("back-to-back 0F-0E: result=%h cb=%b lat=%0d", result, cb_out, n);
      total++; if (n != 9) begin bad++; $display("FAIL b2b_second_latency: got %0d want 9", n); end
      total++; if (result !== 8'h01) begin bad++; $display("FAIL b2b_second_result: got %h want 01", result); end
      total++; if (cb_out !== 1'b0) begin bad++; $display("FAIL b2b_second_cb: got %b want 0", cb_out); end
   endtask

   task automatic test_reset_mid();
      int lat, bc;
      logic to;
      logic saw_done;
      @(negedge clk);
      a_in = 8'hFF; b_in = 8'hFF; op_sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);         // now in busy cycle 4
      rst_n = 1'b0;
      #1;
      $display("mid-shift reset: busy=%b done=%b result=%h cb=%b", busy, done, result, cb_out);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b want 0", done); end
      total++; if (result !== 8'h00) begin bad++; $display("FAIL midrst_result: got %h want 00", result); end
      total++; if (cb_out !== 1'b0) begin bad++; $display("FAIL midrst_cb: got %b want 0", cb_out); end
      saw_done = 1'b0;
      repeat (2) begin @(negedge clk); if (done === 1'b1) saw_done = 1'b1; end
      rst_n = 1'b1;
      repeat (12) begin @(negedge clk); if (done === 1'b1) saw_done = 1'b1; end
      total++; if (saw_done) begin bad++; $display("FAIL midrst_no_done: got done pulse want none"); end
      do_op(8'h7F, 8'h01, 1'b0, lat, bc, to);
      $display("after reset 7F+01: result=%h cb=%b lat=%0d", result, cb_out, lat);
      total++; if (to) begin bad++; $display("FAIL postrst_timeout: no done within bound"); end
      total++; if (result !== 8'h80) begin bad++; $display("FAIL postrst_result: got %h want 80", result); end
      total++; if (cb_out !== 1'b0) begin bad++; $display("FAIL postrst_cb: got %b want 0", cb_out); end
`ifdef SERIAL_ADDSUB_OVF_EN
      total++; if (ovf_out !== 1'b1) begin bad++; $display("FAIL postrst_ovf: got %b want 1", ovf_out); end
`endif
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_back_to_back();
      test_reset_mid();
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
